// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall sequencer and the EXE-stage forwarding unit.
package hazard_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  // Forward-select encoding, shared with the EXE-stage forwarding unit
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // A producer feeds a consumer when it writes a non-zero register the consumer reads
  function automatic logic dep_match(input logic [4:0] dst, input logic reg_write,
                                     input logic [4:0] src, input logic used);
    return used && reg_write && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Bundle of ID/EX/MEM hazard inputs and pipeline control outputs.
interface hazard_if #(parameter int CNT_W = 16);
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_uses_rs;
  logic             ID_uses_rt;
  logic             ID_is_jr;
  logic             ID_take;
  logic [4:0]       EXE_dst;
  logic [4:0]       MEM_dst;
  logic             EXE_RegWrite;
  logic             EXE_MemRead;
  logic             MEM_RegWrite;
  logic             MEM_MemRead;
  logic             mem_busy;
  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             pipe_freeze;
  logic [1:0]       jr_fwd_sel;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: drives stage information, receives control
  modport master (
    output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_is_jr, ID_take,
           EXE_dst, MEM_dst, EXE_RegWrite, EXE_MemRead, MEM_RegWrite, MEM_MemRead, mem_busy,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze, jr_fwd_sel,
           stall_cycles, flush_count
  );

  // Hazard controller side
  modport slave (
    input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_is_jr, ID_take,
           EXE_dst, MEM_dst, EXE_RegWrite, EXE_MemRead, MEM_RegWrite, MEM_MemRead, mem_busy,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze, jr_fwd_sel,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational dependency check: bubble requirement and jr target source.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic       i_uses_rs,
  input  logic       i_uses_rt,
  input  logic       i_is_jr,
  input  logic [4:0] i_exe_dst,
  input  logic       i_exe_reg_write,
  input  logic       i_exe_mem_read,
  input  logic [4:0] i_mem_dst,
  input  logic       i_mem_reg_write,
  input  logic       i_mem_mem_read,
  output logic [1:0] o_n,
  output logic [1:0] o_jr_fwd_sel
);

  logic       w_exe_rs;
  logic       w_exe_rt;
  logic       w_mem_rs;
  logic [1:0] w_n;
  logic [1:0] w_sel;

  // jr always reads rs for its target, even if the decoder left uses_rs clear
  assign w_exe_rs = dep_match(i_exe_dst, i_exe_reg_write, i_rs, i_uses_rs | i_is_jr);
  assign w_exe_rt = dep_match(i_exe_dst, i_exe_reg_write, i_rt, i_uses_rt);
  assign w_mem_rs = dep_match(i_mem_dst, i_mem_reg_write, i_rs, i_uses_rs | i_is_jr);

  // Bubble count and jr source; the EXE producer is younger so it takes priority over MEM
  always_comb begin
    w_n   = 2'd0;
    w_sel = FWD_RF;
    if (i_is_jr) begin
      if (w_exe_rs && i_exe_mem_read) begin
        w_n = 2'd2;
      end else if (w_exe_rs) begin
        w_n = 2'd1;
      end else if (w_mem_rs && i_mem_mem_read) begin
        w_n = 2'd1;
      end else if (w_mem_rs) begin
        w_sel = FWD_EXMEM;
      end else begin
        // MEM/WB producers reach jr through register-file write-through
        w_sel = FWD_RF;
      end
    end else begin
      if ((w_exe_rs || w_exe_rt) && i_exe_mem_read) begin
        w_n = 2'd1;
      end else begin
        w_n = 2'd0;
      end
    end
  end

  assign o_n          = w_n;
  assign o_jr_fwd_sel = w_sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze sequencer with saturating stall and flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  bus
);

  state_e           r_state;
  state_e           r_ret;
  logic [1:0]       r_rem;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  state_e     w_state_nx;
  state_e     w_ret_nx;
  logic [1:0] w_rem_nx;
  state_e     w_eff_state;
  logic [1:0] w_n;
  logic [1:0] w_sel;
  logic       w_stall;
  logic       w_pc_write;
  logic       w_if_id_write;
  logic       w_flush;
  logic       w_bubble;
  logic       w_freeze;
  logic [1:0] w_jr_fwd_sel;

  hazard_detect u_detect (
    .i_rs            (bus.ID_rs),
    .i_rt            (bus.ID_rt),
    .i_uses_rs       (bus.ID_uses_rs),
    .i_uses_rt       (bus.ID_uses_rt),
    .i_is_jr         (bus.ID_is_jr),
    .i_exe_dst       (bus.EXE_dst),
    .i_exe_reg_write (bus.EXE_RegWrite),
    .i_exe_mem_read  (bus.EXE_MemRead),
    .i_mem_dst       (bus.MEM_dst),
    .i_mem_reg_write (bus.MEM_RegWrite),
    .i_mem_mem_read  (bus.MEM_MemRead),
    .o_n             (w_n),
    .o_jr_fwd_sel    (w_sel)
  );

  // Once memory is ready, a frozen sequencer acts as its saved state in the same cycle
  assign w_eff_state = ((r_state == ST_FREEZE) && !bus.mem_busy) ? r_ret : r_state;

  // State register, saved return state and remaining-bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_ret   <= ST_RUN;
      r_rem   <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_ret   <= w_ret_nx;
      r_rem   <= w_rem_nx;
    end
  end

  // Next-state logic; rem is untouched while frozen so the bubble total is preserved
  always_comb begin
    w_state_nx = r_state;
    w_ret_nx   = r_ret;
    w_rem_nx   = r_rem;
    if (bus.mem_busy) begin
      w_state_nx = ST_FREEZE;
      if (r_state != ST_FREEZE) begin
        w_ret_nx = r_state;
      end else begin
        w_ret_nx = r_ret;
      end
    end else begin
      case (w_eff_state)
        ST_RUN: begin
          if (w_n == 2'd2) begin
            w_state_nx = ST_STALL;
            w_rem_nx   = 2'd1;
          end else begin
            // n = 1 resolves by itself when the producer advances
            w_state_nx = ST_RUN;
            w_rem_nx   = 2'd0;
          end
        end
        ST_STALL: begin
          if (r_rem <= 2'd1) begin
            w_state_nx = ST_RUN;
            w_rem_nx   = 2'd0;
          end else begin
            w_state_nx = ST_STALL;
            w_rem_nx   = r_rem - 2'd1;
          end
        end
        default: begin
          w_state_nx = ST_RUN;
          w_rem_nx   = 2'd0;
        end
      endcase
    end
  end

  // Pipeline control outputs; reset forces a held, bubbled pipe
  always_comb begin
    w_stall       = 1'b1;
    w_pc_write    = 1'b0;
    w_if_id_write = 1'b0;
    w_flush       = 1'b0;
    w_bubble      = 1'b1;
    w_freeze      = 1'b0;
    w_jr_fwd_sel  = FWD_RF;
    if (!rst_n) begin
      w_stall = 1'b1;
    end else if (bus.mem_busy) begin
      w_bubble     = 1'b0;
      w_freeze     = 1'b1;
      w_jr_fwd_sel = w_sel;
    end else begin
      case (w_eff_state)
        ST_RUN:   w_stall = (w_n != 2'd0);
        ST_STALL: w_stall = 1'b1;
        default:  w_stall = 1'b1;
      endcase
      w_pc_write    = !w_stall;
      w_if_id_write = !w_stall;
      w_bubble      = w_stall;
      w_flush       = bus.ID_take && !w_stall;
      w_jr_fwd_sel  = w_sel;
    end
  end

  // Saturating performance counters; freeze cycles count as stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= {CNT_W{1'b0}};
      r_flush_count  <= {CNT_W{1'b0}};
    end else begin
      if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign bus.PC_write     = w_pc_write;
  assign bus.IF_ID_write  = w_if_id_write;
  assign bus.IF_ID_flush  = w_flush;
  assign bus.ID_EX_bubble = w_bubble;
  assign bus.pipe_freeze  = w_freeze;
  assign bus.jr_fwd_sel   = w_jr_fwd_sel;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl plus reset and saturation sequences.
module tb_hazard_ctrl;

  localparam int CW = 4;

  // Control bundle {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze, jr_fwd_sel}
  localparam logic [6:0] C_RUN = 7'b1100000;
  localparam logic [6:0] C_STL = 7'b0001000;
  localparam logic [6:0] C_FRZ = 7'b0000100;
  localparam logic [6:0] C_FL  = 7'b1110000;
  localparam logic [6:0] C_FLX = 7'b1110010;
  localparam logic [6:0] C_RST = 7'b0001000;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, jr, take;
    logic [4:0] edst;
    logic       erw, emr;
    logic [4:0] mdst;
    logic       mrw, mmr, busy;
    logic [6:0] ctl;
    logic [3:0] sc, fc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  hazard_if #(.CNT_W(CW)) hif ();
  hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(hif.slave));

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, rt, input logic urs, urt, jr, take,
                              input logic [4:0] edst, input logic erw, emr,
                              input logic [4:0] mdst, input logic mrw, mmr, busy,
                              input logic [6:0] ctl, input logic [3:0] sc, fc);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.jr = jr; v.take = take;
    v.edst = edst; v.erw = erw; v.emr = emr; v.mdst = mdst; v.mrw = mrw; v.mmr = mmr;
    v.busy = busy; v.ctl = ctl; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hif.ID_rs = v.rs; hif.ID_rt = v.rt; hif.ID_uses_rs = v.urs; hif.ID_uses_rt = v.urt;
    hif.ID_is_jr = v.jr; hif.ID_take = v.take;
    hif.EXE_dst = v.edst; hif.EXE_RegWrite = v.erw; hif.EXE_MemRead = v.emr;
    hif.MEM_dst = v.mdst; hif.MEM_RegWrite = v.mrw; hif.MEM_MemRead = v.mmr;
    hif.mem_busy = v.busy;
  endtask

  task automatic check(input string name, input logic [6:0] ctl, input logic [3:0] sc, fc);
    logic [6:0] got;
    got = {hif.PC_write, hif.IF_ID_write, hif.IF_ID_flush, hif.ID_EX_bubble,
           hif.pipe_freeze, hif.jr_fwd_sel};
    n_vec++;
    if (got !== ctl) begin
      n_err++;
      $display("FAIL %s ctl got %b want %b", name, got, ctl);
    end
    n_vec++;
    if (hif.stall_cycles !== sc || hif.flush_count !== fc) begin
      n_err++;
      $display("FAIL %s counters got sc=%0d fc=%0d want sc=%0d fc=%0d",
               name, hif.stall_cycles, hif.flush_count, sc, fc);
    end
  endtask

  initial begin
    vec_t idle;
    vec_t jr_lw;
    idle  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 4'd0, 4'd0);
    jr_lw = mk(5'd31, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_STL, 4'd12, 4'd6);

    // rs  rt  urs urt jr take | edst erw emr | mdst mrw mmr | busy | ctl sc fc
    tbl.push_back(mk(5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0, 5'd0, 1'b0,1'b0, 1'b0, C_RUN, 4'd0,  4'd0));
    tbl.push_back(mk(5'd2,  5'd0, 1'b1,1'b0,1'b0,1'b0, 5'd2, 1'b1,1'b1, 5'd0, 1'b0,1'b0, 1'b0, C_STL, 4'd0,  4'd0));
    tbl.push_back(mk(5'd2,  5'd0, 1'b1,1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0, 5'd2, 1'b1,1'b1, 1'b0, C_RUN, 4'd1,  4'd0));
    tbl.push_back(mk(5'd31, 5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd31,1'b1,1'b1, 5'd0, 1'b0,1'b0, 1'b0, C_STL, 4'd1,  4'd0));
    tbl.push_back(mk(5'd31, 5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0, 5'd31,1'b1,1'b1, 1'b0, C_STL, 4'd2,  4'd0));
    tbl.push_back(mk(5'd31, 5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0, 5'd0, 1'b0,1'b0, 1'b0, C_FL,  4'd3,  4'd0));
    tbl.push_back(mk(5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0, 5'd0, 1'b0,1'b0, 1'b0, C_RUN, 4'd3,  4'd1));
    tbl.push_back(mk(5'd5,  5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0, 5'd5, 1'b1,1'b0, 1'b0, C_FLX, 4'd3,  4'd1));
    tbl.push_back(mk(5'd0,  5'd0, 1'b1,1'b1,1'b0,1'b0, 5'd0, 1'b1,1'b1, 5'd0, 1'b0,1'b0, 1'b0, C_RUN, 4'd3,  4'd2));
    tbl.push_back(mk(5'd7,  5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd7, 1'b1,1'b0, 5'd0, 1'b0,1'b0, 1'b0, C_STL, 4'd3,  4'd2));
    tbl.push_back(mk(5'd7,  5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0, 5'd7, 1'b1,1'b0, 1'b0, C_FLX, 4'd4,  4'd2));
    tbl.push_back(mk(5'd9,  5'd9, 1'b0,1'b1,1'b0,1'b0, 5'd9, 1'b1,1'b1, 5'd0, 1'b0,1'b0, 1'b0, C_STL, 4'd4,  4'd3));
    tbl.push_back(mk(5'd9,  5'd9, 1'b0,1'b0,1'b0,1'b0, 5'd9, 1'b1,1'b1, 5'd0, 1'b0,1'b0, 1'b0, C_RUN, 4'd5,  4'd3));
    tbl.push_back(mk(5'd3,  5'd0, 1'b1,1'b0,1'b0,1'b1, 5'd3, 1'b1,1'b1, 5'd0, 1'b0,1'b0, 1'b0, C_STL, 4'd5,  4'd3));
    tbl.push_back(mk(5'd3,  5'd0, 1'b1,1'b0,1'b0,1'b1, 5'd0, 1'b0,1'b0, 5'd3, 1'b1,1'b1, 1'b0, C_FL,  4'd6,  4'd3));
    tbl.push_back(mk(5'd31, 5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd31,1'b1,1'b1, 5'd0, 1'b0,1'b0, 1'b0, C_STL, 4'd6,  4'd4));
    tbl.push_back(mk(5'd31, 5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0, 5'd31,1'b1,1'b1, 1'b1, C_FRZ, 4'd7,  4'd4));
    tbl.push_back(mk(5'd31, 5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0, 5'd31,1'b1,1'b1, 1'b1, C_FRZ, 4'd8,  4'd4));
    tbl.push_back(mk(5'd31, 5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0, 5'd31,1'b1,1'b1, 1'b1, C_FRZ, 4'd9,  4'd4));
    tbl.push_back(mk(5'd31, 5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0, 5'd31,1'b1,1'b1, 1'b0, C_STL, 4'd10, 4'd4));
    tbl.push_back(mk(5'd31, 5'd0, 1'b1,1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0, 5'd0, 1'b0,1'b0, 1'b0, C_FL,  4'd11, 4'd4));
    tbl.push_back(mk(5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b1, 5'd0, 1'b0,1'b0, 5'd0, 1'b0,1'b0, 1'b1, C_FRZ, 4'd11, 4'd5));
    tbl.push_back(mk(5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b1, 5'd0, 1'b0,1'b0, 5'd0, 1'b0,1'b0, 1'b0, C_FL,  4'd12, 4'd5));
    tbl.push_back(mk(5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0, 5'd0, 1'b0,1'b0, 1'b0, C_RUN, 4'd12, 4'd6));

    // Reset state with a hazard present on the inputs
    apply(jr_lw);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("reset", C_RST, 4'd0, 4'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      apply(tbl[i]);
      #2;
      check($sformatf("v%0d", i), tbl[i].ctl, tbl[i].sc, tbl[i].fc);
    end

    // Reset asserted in STALL
    @(negedge clk);
    apply(jr_lw);
    #2;
    check("enter_stall", C_STL, 4'd12, 4'd6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_stall", C_RST, 4'd0, 4'd0);
    @(negedge clk);
    apply(idle);
    rst_n = 1'b1;
    #2;
    check("after_stall_rst", C_RUN, 4'd0, 4'd0);

    // Reset asserted in FREEZE
    @(negedge clk);
    idle.busy = 1'b1;
    apply(idle);
    #2;
    check("enter_freeze", C_FRZ, 4'd0, 4'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_freeze", C_RST, 4'd0, 4'd0);
    @(negedge clk);
    idle.busy = 1'b0;
    apply(idle);
    rst_n = 1'b1;
    #2;
    check("after_freeze_rst", C_RUN, 4'd0, 4'd0);

    // Stall counter saturation through a long freeze
    idle.busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      apply(idle);
    end
    @(negedge clk);
    #2;
    check("stall_sat", C_FRZ, 4'd15, 4'd0);

    // Flush counter saturation through a run of taken transfers
    idle.busy = 1'b0;
    idle.take = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      apply(idle);
    end
    @(negedge clk);
    #2;
    check("flush_sat", C_FL, 4'd15, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
